// File: rtl/alu_decode_pkg.sv
// Shared decode constants, ALU function codes and the decoded-operation payload.
// The ALU_* codes mirror the core-wide constants; ALU_ADD must stay 0 so a cleared payload reads as ADD.
package alu_decode_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FUNC_W = 5;

  localparam logic [FUNC_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [FUNC_W-1:0] ALU_SLL  = 5'd2;
  localparam logic [FUNC_W-1:0] ALU_SLT  = 5'd3;
  localparam logic [FUNC_W-1:0] ALU_SLTU = 5'd4;
  localparam logic [FUNC_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [FUNC_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [FUNC_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [FUNC_W-1:0] ALU_OR   = 5'd8;
  localparam logic [FUNC_W-1:0] ALU_AND  = 5'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [FUNC_W-1:0] alu_function;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              is_branch;
    logic              branch_invert;
    logic              illegal;
  } decoded_op_t;

  // Register/immediate arithmetic funct3 map; alt selects SUB/SRA.
  function automatic logic [FUNC_W-1:0] arith_func(input logic [2:0] f3, input logic alt);
    logic [FUNC_W-1:0] fn;
    case (f3)
      F3_ADD_SUB: fn = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     fn = ALU_SLL;
      F3_SLT:     fn = ALU_SLT;
      F3_SLTU:    fn = ALU_SLTU;
      F3_XOR:     fn = ALU_XOR;
      F3_SRL_SRA: fn = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      fn = ALU_OR;
      default:    fn = ALU_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational RV32I decode of one instruction into the ALU operation payload.
module alu_decode_comb
  import alu_decode_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output decoded_op_t       op_c
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // Any illegal encoding collapses to a zeroed ADD with only the illegal flag set.
  always_comb begin
    logic legal;
    legal = 1'b1;
    op_c  = '0;
    case (opcode)
      OPC_OP: begin
        op_c.op_a = rs1_data;
        op_c.op_b = rs2_data;
        if (f7 == F7_BASE) begin
          op_c.alu_function = arith_func(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
          op_c.alu_function = arith_func(f3, 1'b1);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        op_c.op_a         = rs1_data;
        op_c.op_b         = imm_i;
        op_c.alu_function = arith_func(f3, 1'b0);
        if (f3 == F3_SLL) begin
          op_c.op_b = shamt;
          if (f7 != F7_BASE) legal = 1'b0;
        end else if (f3 == F3_SRL_SRA) begin
          op_c.op_b = shamt;
          if (f7 == F7_ALT) op_c.alu_function = ALU_SRA;
          else if (f7 != F7_BASE) legal = 1'b0;
        end
      end
      OPC_LUI: begin
        op_c.op_b = imm_u;
      end
      OPC_AUIPC: begin
        op_c.op_a = pc;
        op_c.op_b = imm_u;
      end
      OPC_LOAD: begin
        op_c.op_a = rs1_data;
        op_c.op_b = imm_i;
      end
      OPC_STORE: begin
        op_c.op_a = rs1_data;
        op_c.op_b = imm_s;
      end
      OPC_BRANCH: begin
        op_c.op_a      = rs1_data;
        op_c.op_b      = rs2_data;
        op_c.is_branch = 1'b1;
        case (f3)
          F3_BEQ:  op_c.alu_function = ALU_SUB;
          F3_BNE:  begin op_c.alu_function = ALU_SUB;  op_c.branch_invert = 1'b1; end
          F3_BLT:  op_c.alu_function = ALU_SLT;
          F3_BGE:  begin op_c.alu_function = ALU_SLT;  op_c.branch_invert = 1'b1; end
          F3_BLTU: op_c.alu_function = ALU_SLTU;
          F3_BGEU: begin op_c.alu_function = ALU_SLTU; op_c.branch_invert = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        op_c.op_a = pc;
        op_c.op_b = 32'd4;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      op_c         = '0;
      op_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with a 2-entry skid buffer on valid/ready handshakes.
// Define ALU_DECODE_PERF_EN to add the perf_accepted / perf_illegal counters.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_alu_function,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic            out_is_branch,
  output logic            out_branch_invert,
  output logic            out_illegal
`ifdef ALU_DECODE_PERF_EN
  ,
  output logic [31:0]     perf_accepted,
  output logic [31:0]     perf_illegal
`endif
);

  decoded_op_t dec_c;
  decoded_op_t main_q;
  decoded_op_t skid_q;
  logic        main_valid;
  logic        skid_valid;
  logic        in_xfer;
  logic        out_xfer;
  logic        main_free;

  alu_decode_comb u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .op_c     (dec_c)
  );

  assign in_ready  = !skid_valid && !reset;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign main_free = !main_valid || out_xfer;

  // Skid is only ever filled while main stalls, so it drains first when main frees up.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q     <= dec_c;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec_c;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid         = main_valid;
  assign out_alu_function  = main_q.alu_function;
  assign out_op_a          = main_q.op_a;
  assign out_op_b          = main_q.op_b;
  assign out_is_branch     = main_q.is_branch;
  assign out_branch_invert = main_q.branch_invert;
  assign out_illegal       = main_q.illegal;

`ifdef ALU_DECODE_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_accepted <= '0;
      perf_illegal  <= '0;
    end else begin
      if (in_xfer) perf_accepted <= perf_accepted + 32'd1;
      if (out_xfer && main_q.illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized self-checking bench for alu_decode_stage against a queue-based decode model.
module tb_alu_decode_stage;
  import alu_decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_function;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic        out_is_branch;
  logic        out_branch_invert;
  logic        out_illegal;
`ifdef ALU_DECODE_PERF_EN
  logic [31:0] perf_accepted;
  logic [31:0] perf_illegal;
  logic [31:0] m_acc;
  logic [31:0] m_ill;
`endif

  always #5 clock = ~clock;

  alu_decode_stage dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .in_rs1_data       (in_rs1_data),
    .in_rs2_data       (in_rs2_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_alu_function  (out_alu_function),
    .out_op_a          (out_op_a),
    .out_op_b          (out_op_b),
    .out_is_branch     (out_is_branch),
    .out_branch_invert (out_branch_invert),
    .out_illegal       (out_illegal)
`ifdef ALU_DECODE_PERF_EN
    ,
    .perf_accepted     (perf_accepted),
    .perf_illegal      (perf_illegal)
`endif
  );

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        inv;
    logic        ill;
  } exp_t;

  int passed = 0;
  int total  = 0;
  exp_t q[$];
  logic [4:0] base_tab [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decode written from the instruction-set rules, table-driven.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_u;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u = ins & 32'hFFFF_F000;
    e  = '{fn: ALU_ADD, a: 32'd0, b: 32'd0, br: 1'b0, inv: 1'b0, ill: 1'b0};
    ok = 1'b1;
    case (opc)
      7'h33: begin
        e.a = r1; e.b = r2; e.fn = base_tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.fn = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.fn = ALU_SRA;
        else if (f7 != 7'h00) ok = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.fn = base_tab[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = 32'(ins[24:20]);
          if (f7 == 7'h20 && f3 == 3'd5) e.fn = ALU_SRA;
          else if (f7 != 7'h00) ok = 1'b0;
        end else begin
          e.b = imm_i;
        end
      end
      7'h37: e.b = imm_u;
      7'h17: begin e.a = pc; e.b = imm_u; end
      7'h03: begin e.a = r1; e.b = imm_i; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1; e.inv = f3[0];
        if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
        else if (!f3[2]) e.fn = ALU_SUB;
        else e.fn = f3[1] ? ALU_SLTU : ALU_SLT;
      end
      7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; end
      default: ok = 1'b0;
    endcase
    if (!ok) e = '{fn: ALU_ADD, a: 32'd0, b: 32'd0, br: 1'b0, inv: 1'b0, ill: 1'b1};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [0:9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F};
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opcs[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Per-cycle comparison of the DUT against the FIFO of expected operations.
  logic prev_reset = 1'b0;
  logic hold_valid = 1'b0;
  exp_t held;
  always @(negedge clock) begin
    if (reset) begin
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
      if (prev_reset) begin
        check("out_valid_reset", 32'(out_valid), 32'd0);
        check("fn_reset", 32'(out_alu_function), 32'(ALU_ADD));
        check("op_a_reset", out_op_a, 32'd0);
        check("op_b_reset", out_op_b, 32'd0);
        check("flags_reset", 32'({out_is_branch, out_branch_invert, out_illegal}), 32'd0);
`ifdef ALU_DECODE_PERF_EN
        m_acc = 32'd0;
        m_ill = 32'd0;
        check("perf_acc_reset", perf_accepted, 32'd0);
        check("perf_ill_reset", perf_illegal, 32'd0);
`endif
      end
      q.delete();
      hold_valid = 1'b0;
      prev_reset = 1'b1;
    end else begin
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("alu_function", 32'(out_alu_function), 32'(q[0].fn));
        check("op_a", out_op_a, q[0].a);
        check("op_b", out_op_b, q[0].b);
        check("is_branch", 32'(out_is_branch), 32'(q[0].br));
        check("branch_invert", 32'(out_branch_invert), 32'(q[0].inv));
        check("illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      if (hold_valid) begin
        check("hold_fn", 32'(out_alu_function), 32'(held.fn));
        check("hold_a", out_op_a, held.a);
        check("hold_b", out_op_b, held.b);
      end
`ifdef ALU_DECODE_PERF_EN
      check("perf_accepted", perf_accepted, m_acc);
      check("perf_illegal", perf_illegal, m_ill);
`endif
      hold_valid = 1'b0;
      if (out_valid && !out_ready) begin
        hold_valid = 1'b1;
        held = '{fn: out_alu_function, a: out_op_a, b: out_op_b, br: 1'b0, inv: 1'b0, ill: 1'b0};
      end
      if (out_valid && out_ready && q.size() != 0) begin
`ifdef ALU_DECODE_PERF_EN
        if (q[0].ill) m_ill = m_ill + 32'd1;
`endif
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
`ifdef ALU_DECODE_PERF_EN
        m_acc = m_acc + 32'd1;
`endif
      end
      prev_reset = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic rdy);
    in_valid    = v;
    in_instr    = ins;
    in_rs1_data = r1;
    in_rs2_data = r2;
    in_pc       = in_pc + 32'd4;
    out_ready   = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t e;
    // Hand-computed pins on the reference model.
    e = model(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check("pin_add_fn", 32'(e.fn), 32'(ALU_ADD));
    check("pin_add_ab", e.a + e.b, 32'd12);
    e = model(32'hFFF0C093, 32'h0, 32'h0F0F0F0F, 32'h0);
    check("pin_xori_fn", 32'(e.fn), 32'(ALU_XOR));
    check("pin_xori_b", e.b, 32'hFFFFFFFF);
    e = model(32'h4030D093, 32'h0, 32'h1234, 32'h0);
    check("pin_srai_fn", 32'(e.fn), 32'(ALU_SRA));
    check("pin_srai_b", e.b, 32'd3);
    e = model(32'h02031063, 32'h0, 32'd9, 32'd9);
    check("pin_bne", 32'({e.fn, e.br, e.inv, e.ill}), 32'({ALU_SUB, 3'b110}));
    e = model(32'hFFFFFFFF, 32'h40, 32'd1, 32'd2);
    check("pin_illegal", 32'({e.fn, e.br, e.inv, e.ill}), 32'({ALU_ADD, 3'b001}));
    check("pin_illegal_ops", e.a | e.b, 32'd0);

    // Reset with an add already offered.
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
    in_rs1_data = 32'd5; in_rs2_data = 32'd7; in_pc = 32'h100; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    drive(1'b1, 32'hFFF0C093, 32'h0F0F0F0F, 32'd0, 1'b1);
    drive(1'b1, 32'h4030D093, 32'h8000_0000, 32'd0, 1'b1);
    drive(1'b1, 32'h02031063, 32'd9, 32'd9, 1'b1);
    drive(1'b1, 32'hFFFFFFFF, 32'd3, 32'd4, 1'b1);
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);

    // Backpressure: A to main, B to skid, C stalls until the output drains.
    drive(1'b1, 32'h00310233, 32'd1, 32'd2, 1'b0);
    drive(1'b1, 32'h40520333, 32'd10, 32'd3, 1'b0);
    drive(1'b1, 32'h0073F433, 32'hF0, 32'h3C, 1'b0);
    drive(1'b1, 32'h0073F433, 32'hF0, 32'h3C, 1'b0);
    drive(1'b1, 32'h0073F433, 32'hF0, 32'h3C, 1'b1);
    drive(1'b1, 32'h0073F433, 32'hF0, 32'h3C, 1'b1);
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom_range(0, 3) != 0);
    end
    reset = 1'b0;

`ifdef ALU_DECODE_PERF_EN
    // Preload the accepted counter to exercise its wrap.
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    force dut.perf_accepted = 32'hFFFFFFFF;
    m_acc = 32'hFFFFFFFF;
    #1 release dut.perf_accepted;
    @(posedge clock);
    #1;
    drive(1'b1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
`endif

    repeat (4) drive(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
